// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with a
// per-register pending-write (busy) scoreboard and optional same-cycle
// write-to-read bypass.
//
// Interface semantics: there are no handshakes. Writes, busy_set and flush
// are sampled unconditionally on every rising edge when enabled. Reads are
// purely combinational from rd_addr / we / wr_addr / wr_data.
module regfile_mp #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic                  busy_set,
  input  logic [AW-1:0]         busy_addr,
  input  logic                  flush
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [NWR-1:0]   wr_ok;

  // Per-port write qualification: writes to x0 are dropped when hardwired.
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_ok[j] = we[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0));
    end
  end

  // Storage update; ports are visited in ascending order so the last
  // non-blocking assignment (highest-index port) wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j]) regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  // Busy next-state: assignments are applied lowest priority first so that
  // flush beats busy_set, and busy_set beats a completing write.
  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NWR; j++) begin
      if (wr_ok[j]) busy_next[wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (busy_set) busy_next[busy_addr] = 1'b1;
    if (flush) busy_next = '0;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  // Combinational read ports with optional forwarding of same-cycle writes;
  // forwarded data is not pending, so busy reads 0 on a bypass hit.
  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      a = rd_addr[i*AW +: AW];
      d = regs[a];
      b = busy[a];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_ok[j] && (wr_addr[j*AW +: AW] == a)) begin
            d = wr_data[j*XLEN +: XLEN];
            b = 1'b0;
          end
        end
      end
      if (((ZERO_REG != 0) && (a == '0)) || !rst_n) begin
        d = '0;
        b = 1'b0;
      end
      rd_data[i*XLEN +: XLEN] = d;
      rd_busy[i]              = b;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp. Two instances share the
// stimulus: one with bypass enabled, one without. The driver sets inputs
// 1 time unit after each rising edge and queues the expected read results;
// the monitor drains the queue on the following falling edge.
module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int EW   = XLEN + 3;  // {sel, port, busy, data}

  logic              clk;
  logic              rst_n;
  logic [2*AW-1:0]   rd_addr;
  logic [2*XLEN-1:0] rd_data_bp, rd_data_nb;
  logic [1:0]        rd_busy_bp, rd_busy_nb;
  logic [1:0]        we;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic              busy_set;
  logic [AW-1:0]     busy_addr;
  logic              flush;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  logic          chk_valid;
  int            checks;
  int            failures;

  regfile_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_bp),
    .rd_busy(rd_busy_bp), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set(busy_set), .busy_addr(busy_addr), .flush(flush)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .rd_busy(rd_busy_nb), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_set(busy_set), .busy_addr(busy_addr), .flush(flush)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    we        = '0;
    busy_set  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic rd(input int p, input int a);
    rd_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
    we[p]                   = 1'b1;
    wr_addr[p*AW +: AW]     = a[AW-1:0];
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic mark(input int a);
    busy_set  = 1'b1;
    busy_addr = a[AW-1:0];
  endtask

  // sel: 0 = bypass instance, 1 = no-bypass instance
  task automatic expect_rd(input int sel, input int p, input logic b,
                           input logic [XLEN-1:0] d, input string nm);
    exp_q.push_back({sel[0], p[0], b, d});
    name_q.push_back(nm);
    chk_valid = 1'b1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (chk_valid) begin
      while (exp_q.size() > 0) begin
        automatic logic [EW-1:0] e  = exp_q.pop_front();
        automatic string         nm = name_q.pop_front();
        automatic int            p  = int'(e[EW-2]);
        automatic logic [XLEN-1:0] ad;
        automatic logic            ab;
        if (e[EW-1]) begin
          ad = rd_data_nb[p*XLEN +: XLEN];
          ab = rd_busy_nb[p];
        end else begin
          ad = rd_data_bp[p*XLEN +: XLEN];
          ab = rd_busy_bp[p];
        end
        checks++;
        if (ad !== e[XLEN-1:0] || ab !== e[XLEN]) begin
          failures++;
          $display("FAIL %s: got data=%0h busy=%0b, want data=%0h busy=%0b",
                   nm, ad, ab, e[XLEN-1:0], e[XLEN]);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    checks = 0; failures = 0; chk_valid = 1'b0;
    rst_n = 1'b0; rd_addr = '0; we = '0; wr_addr = '0; wr_data = '0;
    busy_set = 1'b0; busy_addr = '0; flush = 1'b0;

    // Reset state
    step();
    rd(0, 5); rd(1, 31);
    expect_rd(0, 0, 0, 64'd0, "rst_x5");
    expect_rd(0, 1, 0, 64'd0, "rst_x31");

    // Basic write/read, bypass in the write cycle
    step(); rst_n = 1'b1;
    wr(0, 2, 64'd10); wr(1, 5, 64'd7); rd(0, 2); rd(1, 5);
    expect_rd(0, 0, 0, 64'd10, "bp_wcyc_x2");
    expect_rd(0, 1, 0, 64'd7,  "bp_wcyc_x5");
    expect_rd(1, 0, 0, 64'd0,  "nb_wcyc_x2");
    expect_rd(1, 1, 0, 64'd0,  "nb_wcyc_x5");
    step();
    expect_rd(0, 0, 0, 64'd10, "bp_after_x2");
    expect_rd(0, 1, 0, 64'd7,  "bp_after_x5");
    expect_rd(1, 0, 0, 64'd10, "nb_after_x2");
    expect_rd(1, 1, 0, 64'd7,  "nb_after_x5");

    // Zero register
    step(); wr(0, 0, 64'h1234); mark(0); rd(0, 0); rd(1, 0);
    expect_rd(0, 0, 0, 64'd0, "zero_wcyc_bp");
    expect_rd(1, 1, 0, 64'd0, "zero_wcyc_nb");
    step();
    expect_rd(0, 0, 0, 64'd0, "zero_after_bp");
    expect_rd(1, 0, 0, 64'd0, "zero_after_nb");

    // Collision on x9: port1 wins
    step(); wr(0, 9, 64'd1); wr(1, 9, 64'd2); rd(0, 9); rd(1, 9);
    expect_rd(0, 0, 0, 64'd2, "coll_wcyc_bp");
    expect_rd(1, 1, 0, 64'd0, "coll_wcyc_nb");
    step();
    expect_rd(0, 0, 0, 64'd2, "coll_after_bp");
    expect_rd(1, 0, 0, 64'd2, "coll_after_nb");

    // Scoreboard on x3
    step(); mark(3); rd(0, 3); rd(1, 2);
    expect_rd(0, 0, 0, 64'd0, "sb_preset");
    step();
    expect_rd(0, 0, 1, 64'd0, "sb_set_bp");
    expect_rd(1, 0, 1, 64'd0, "sb_set_nb");
    expect_rd(0, 1, 0, 64'd10, "sb_other_reg");
    step();
    expect_rd(0, 0, 1, 64'd0, "sb_hold");
    step(); wr(0, 3, 64'd42);
    expect_rd(0, 0, 0, 64'd42, "sb_wr_bp");
    expect_rd(1, 0, 1, 64'd0,  "sb_wr_nb");
    step();
    expect_rd(0, 0, 0, 64'd42, "sb_clr_bp");
    expect_rd(1, 0, 0, 64'd42, "sb_clr_nb");
    step(); mark(3); wr(1, 3, 64'd55);
    expect_rd(0, 0, 0, 64'd55, "sb_simul_wcyc_bp");
    expect_rd(1, 0, 0, 64'd42, "sb_simul_wcyc_nb");
    step();
    expect_rd(0, 0, 1, 64'd55, "sb_simul_after_bp");
    expect_rd(1, 0, 1, 64'd55, "sb_simul_after_nb");

    // Flush with simultaneous busy_set
    step(); mark(1);
    step(); mark(2);
    step(); mark(4); flush = 1'b1; rd(0, 1); rd(1, 2);
    expect_rd(0, 0, 1, 64'd0,  "fl_pre_x1");
    expect_rd(0, 1, 1, 64'd10, "fl_pre_x2");
    step();
    expect_rd(0, 0, 0, 64'd0,  "fl_x1");
    expect_rd(0, 1, 0, 64'd10, "fl_x2");
    step(); rd(0, 3); rd(1, 4);
    expect_rd(0, 0, 0, 64'd55, "fl_x3");
    expect_rd(1, 1, 0, 64'd0,  "fl_x4");

    // Asynchronous reset between edges
    step(); wr(0, 5, 64'hDEAD); mark(5); rd(0, 5); rd(1, 2);
    step();
    expect_rd(0, 0, 1, 64'hDEAD, "ar_pre_x5");
    step(); rst_n = 1'b0;
    expect_rd(0, 0, 0, 64'd0, "ar_x5_bp");
    expect_rd(1, 0, 0, 64'd0, "ar_x5_nb");
    expect_rd(0, 1, 0, 64'd0, "ar_x2_bp");
    step(); rst_n = 1'b1;
    expect_rd(0, 0, 0, 64'd0, "ar_post_x5");
    expect_rd(1, 1, 0, 64'd0, "ar_post_x2");
    step();

    // Bounded drain of the scoreboard
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
